issue_unit: RTL and testbench
=============================

# issue_unit

Issue arbiter between the four issue queues (integer, mult, div, mem) and the execution units. Each cycle it grants every queue whose ready instruction can issue without a common data bus (CDB) conflict, and pulses that queue's issue-done input. It books each granted unit's future CDB cycle in a reservation shift register and tells the CDB mux which unit owns the bus each cycle. It also serialises the non-pipelined divider and prevents integer-queue starvation.

## Interface
Parameters:
- INT_LAT, 1, integer unit latency (issue to CDB, cycles)
- MEM_LAT, 2, load/store unit latency
- MULT_LAT, 4, multiplier latency (pipelined)
- DIV_LAT, 7, divider latency (non-pipelined)
- STARVE_LIM, 8, consecutive integer denials before hold mode
- Legal values: all four latencies distinct, each in 1..15.
- MAXL = max of the four latencies.

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- int_ready, mult_ready, div_ready, mem_ready  in  1 each  queue has an issuable instruction
- int_done, mult_done, div_done, mem_done  out  1 each  issue grant; connects to the queue's issue-done input; combinational
- cdb_sel  out  4  one-hot CDB owner this cycle, bits {mem,div,mult,int}; registered
- cdb_valid  out  1  OR of cdb_sel
- div_busy  out  1  divider occupied

## Operation
- Reservation register: slots 0..MAXL, each holding a valid bit and a 2-bit unit id. Slot k set means the CDB in cycle now+k is booked for that unit.
- Grant conditions for unit X with latency L_X (evaluated combinationally):
  - grant_X = X_ready & !slot[L_X].valid & !rst
  - div additionally requires div_busy == 0.
  - mult, div and mem additionally require hold == 0.
- Independent grants: the latencies are distinct, so any subset of the four may be granted in the same cycle.
- Register update at the clock edge:
  - slot'[k] = slot[k+1] for k < MAXL; slot'[MAXL] = empty.
  - Each grant_X writes {valid, id_X} into slot'[L_X - 1].
- CDB owner: cdb_sel is the one-hot decode of slot[0].
- Divider counter (4 bits):
  - On grant_div, load DIV_LAT-1; otherwise decrement while nonzero.
  - div_busy = (counter != 0).
  - The divider may be granted again in the cycle its previous result is on the CDB.
- Starvation counter (width clog2(STARVE_LIM+1)):
  - Increment, saturating at STARVE_LIM, when int_ready & !grant_int.
  - Clear on grant_int or when int_ready is low.
  - hold = (counter == STARVE_LIM).
  - With hold set, slot[INT_LAT] frees within MAXL cycles, so the integer queue is then granted; its grant clears the counter.

## Timing
- Grant latency: grant appears in the same cycle as ready. The queue dequeues at that clock edge.
- CDB latency: unit X granted in cycle t owns the CDB in cycle t+L_X (cdb_sel bit high for exactly one cycle).
- Reset values: all slots empty, both counters 0. Hence cdb_sel = 0, cdb_valid = 0, div_busy = 0, and all done outputs 0 while rst is high.
- Reset mid-operation: all bookings are discarded immediately. No cdb_sel pulse follows for instructions granted before reset.
- Ready dropping: a ready that drops in the cycle after a grant has no effect; bookings are never cancelled.
- Booking invariant: no slot is ever written twice. Distinct latencies plus the free-slot check guarantee this; verification asserts it.

## Structure
- Shared package holds:
  - the unit id enum: UNIT_INT = 0, UNIT_MULT = 1, UNIT_DIV = 2, UNIT_MEM = 3;
  - the default latency constants;
  - the reservation slot struct {valid, id}.
- One sub-module: cdb_reservation_sr (the parameterised slot array). Its inputs are per-unit write strobes with a fixed write index; its outputs are the per-slot valid bits and the slot-0 id.
- Grant logic, divider counter and starvation counter live in issue_unit.

## Test plan
- Reset: hold all ready inputs high during rst → all done outputs 0, cdb_sel = 0, div_busy = 0. Release rst at t0 → all four granted at t0.
- Integer stream: int_ready held high from t0 → int_done every cycle; cdb_sel = 0001 every cycle from t0+1.
- Conflict: mult granted at t0, int_ready high only from t0+3 → int denied at t0+3. At t0+4, cdb_sel = 0010 and int is granted. At t0+5, cdb_sel = 0001.
- Divider: div_ready held high from t0 → div_done at t0 and t0+7 only; div_busy high t0+1..t0+6; cdb_sel = 0100 at t0+7 and t0+14.
- All four ready at idle t0, each for one cycle → four grants at t0. cdb_sel = 0001 at t0+1, 1000 at t0+2, 0010 at t0+4, 0100 at t0+7; cdb_valid = 0 in all other cycles.
- Starvation:
  - Setup: mult_ready held high from t0; int_ready held high from t0+3.
  - int is denied for 8 cycles (t0+3..t0+10); hold asserts at t0+11 and mult_done is 0 from t0+11.
  - int_done occurs at t0+14; the starvation counter clears and mult_done resumes at t0+15.

Source files
------------

// File: rtl/issue_unit_pkg.sv
// Shared types and default latencies for the issue arbiter and its CDB reservation register.
// Pure definitions, no logic.
package issue_unit_pkg;

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_MULT = 2'd1,
        UNIT_DIV  = 2'd2,
        UNIT_MEM  = 2'd3
    } unit_id_e;

    localparam int DEF_INT_LAT    = 1;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_MULT_LAT   = 4;
    localparam int DEF_DIV_LAT    = 7;
    localparam int DEF_STARVE_LIM = 8;

    typedef struct packed {
        logic     valid;
        unit_id_e id;
    } slot_t;

    function automatic int max_lat(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // One-hot CDB owner in {mem,div,mult,int} bit order; zero when nothing is booked.
    function automatic logic [3:0] unit_onehot(input logic valid, input unit_id_e id);
        logic [3:0] oh;
        oh = '0;
        if (valid) oh = 4'b0001 << id;
        return oh;
    endfunction

endpackage

// File: rtl/issue_unit_if.sv
// Queue-side handshake bundle: per-queue ready in, per-queue issue grant out, plus CDB ownership.
// master = issue queues / CDB mux side, slave = issue_unit.
interface issue_if;
    logic       int_ready;
    logic       mult_ready;
    logic       div_ready;
    logic       mem_ready;
    logic       int_done;
    logic       mult_done;
    logic       div_done;
    logic       mem_done;
    logic [3:0] cdb_sel;
    logic       cdb_valid;
    logic       div_busy;

    modport master (
        output int_ready, mult_ready, div_ready, mem_ready,
        input  int_done, mult_done, div_done, mem_done,
        input  cdb_sel, cdb_valid, div_busy
    );

    modport slave (
        input  int_ready, mult_ready, div_ready, mem_ready,
        output int_done, mult_done, div_done, mem_done,
        output cdb_sel, cdb_valid, div_busy
    );
endinterface

// File: rtl/issue_unit_cdb_reservation_sr.sv
// CDB reservation shift register: slot k books the bus k cycles ahead; shifts one slot per clock.
// Writes land one cycle after the grant at slot L-1; no backpressure, callers must check slot L is free.
module cdb_reservation_sr
    import issue_unit_pkg::*;
#(
    parameter int INT_LAT  = DEF_INT_LAT,
    parameter int MEM_LAT  = DEF_MEM_LAT,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int MAXL     = max_lat(INT_LAT, MEM_LAT, MULT_LAT, DIV_LAT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_int_i,
    input  logic            wr_mult_i,
    input  logic            wr_div_i,
    input  logic            wr_mem_i,
    output logic [MAXL:0]   slot_vld_o,
    output unit_id_e        slot0_id_o
);

    slot_t slot_q [0:MAXL];
    slot_t slot_d [0:MAXL];

    always_comb begin
        for (int k = 0; k < MAXL; k++) begin
            slot_d[k] = slot_q[k+1];
        end
        slot_d[MAXL] = '0;
        if (wr_int_i)  slot_d[INT_LAT-1]  = '{valid: 1'b1, id: UNIT_INT};
        if (wr_mult_i) slot_d[MULT_LAT-1] = '{valid: 1'b1, id: UNIT_MULT};
        if (wr_div_i)  slot_d[DIV_LAT-1]  = '{valid: 1'b1, id: UNIT_DIV};
        if (wr_mem_i)  slot_d[MEM_LAT-1]  = '{valid: 1'b1, id: UNIT_MEM};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= MAXL; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k <= MAXL; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k <= MAXL; k++) begin
            slot_vld_o[k] = slot_q[k].valid;
        end
    end

    assign slot0_id_o = slot_q[0].id;

    // A booking may only target a slot that is empty once the shift has happened.
    a_int_free:  assert property (@(posedge clk) disable iff (rst) wr_int_i  |-> !slot_q[INT_LAT].valid);
    a_mult_free: assert property (@(posedge clk) disable iff (rst) wr_mult_i |-> !slot_q[MULT_LAT].valid);
    a_div_free:  assert property (@(posedge clk) disable iff (rst) wr_div_i  |-> !slot_q[DIV_LAT].valid);
    a_mem_free:  assert property (@(posedge clk) disable iff (rst) wr_mem_i  |-> !slot_q[MEM_LAT].valid);

endmodule

// File: rtl/issue_unit.sv
// Issue arbiter: same-cycle grants to int/mult/div/mem queues avoiding CDB clashes; CDB owner L cycles later.
// A ready queue simply waits while its result slot is booked, the divider is busy, or integer starvation hold is on.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int INT_LAT    = DEF_INT_LAT,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int MULT_LAT   = DEF_MULT_LAT,
    parameter int DIV_LAT    = DEF_DIV_LAT,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic  clk,
    input  logic  rst,
    issue_if.slave iss
);

    localparam int MAXL = max_lat(INT_LAT, MEM_LAT, MULT_LAT, DIV_LAT);
    localparam int SW   = $clog2(STARVE_LIM + 1);

    logic [MAXL:0] slot_vld;
    unit_id_e      slot0_id;
    logic          unused_slots;

    logic          grant_int;
    logic          grant_mult;
    logic          grant_div;
    logic          grant_mem;
    logic          hold;
    logic          div_busy;

    logic [3:0]    div_cnt_q;
    logic [3:0]    div_cnt_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    cdb_reservation_sr #(
        .INT_LAT  (INT_LAT),
        .MEM_LAT  (MEM_LAT),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .MAXL     (MAXL)
    ) u_resv (
        .clk        (clk),
        .rst        (rst),
        .wr_int_i   (grant_int),
        .wr_mult_i  (grant_mult),
        .wr_div_i   (grant_div),
        .wr_mem_i   (grant_mem),
        .slot_vld_o (slot_vld),
        .slot0_id_o (slot0_id)
    );

    // Only the slots at each unit's latency (and slot 0) matter here.
    assign unused_slots = ^slot_vld;

    assign hold     = (starve_q == SW'(STARVE_LIM));
    assign div_busy = (div_cnt_q != 4'd0);

    // Latencies are distinct, so each grant is independent of the others.
    assign grant_int  = iss.int_ready  & ~slot_vld[INT_LAT]  & ~rst;
    assign grant_mult = iss.mult_ready & ~slot_vld[MULT_LAT] & ~hold & ~rst;
    assign grant_div  = iss.div_ready  & ~slot_vld[DIV_LAT]  & ~hold & ~div_busy & ~rst;
    assign grant_mem  = iss.mem_ready  & ~slot_vld[MEM_LAT]  & ~hold & ~rst;

    assign iss.int_done  = grant_int;
    assign iss.mult_done = grant_mult;
    assign iss.div_done  = grant_div;
    assign iss.mem_done  = grant_mem;

    assign iss.cdb_sel   = unit_onehot(slot_vld[0], slot0_id);
    assign iss.cdb_valid = slot_vld[0];
    assign iss.div_busy  = div_busy;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (grant_div) begin
            div_cnt_d = 4'(DIV_LAT - 1);
        end else if (div_cnt_q != 4'd0) begin
            div_cnt_d = div_cnt_q - 4'd1;
        end
    end

    always_comb begin
        starve_d = '0;
        if (iss.int_ready & ~grant_int) begin
            starve_d = hold ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            starve_q  <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed vector table, hand-written divider/starvation sequences,
// and random traffic against a cycle-indexed booking model.
module tb_issue_unit;
    import issue_unit_pkg::*;

    localparam int L_INT  = 1;
    localparam int L_MEM  = 2;
    localparam int L_MULT = 4;
    localparam int L_DIV  = 7;
    localparam int SLIM   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_if bus();

    issue_unit #(
        .INT_LAT    (L_INT),
        .MEM_LAT    (L_MEM),
        .MULT_LAT   (L_MULT),
        .DIV_LAT    (L_DIV),
        .STARVE_LIM (SLIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .iss (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] a_done, a_sel;
    logic       a_valid, a_busy;
    logic [3:0] m_done, m_sel;
    logic       m_busy;

    // Model: booked[c % 64] = unit owning the CDB in absolute cycle c, -1 when free.
    int booked [64];
    int div_end  = 0;
    int deny_run = 0;

    typedef struct {
        logic       r;
        logic [3:0] rdy;
        logic [3:0] done;
        logic [3:0] sel;
        logic       busy;
    } vec_t;
    vec_t tbl[$];

    function automatic int lat_of(input int u);
        case (u)
            0:       return L_INT;
            1:       return L_MULT;
            2:       return L_DIV;
            default: return L_MEM;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] rdy);
        logic [3:0] g;
        logic       hold;
        g = '0;
        if (r) begin
            for (int i = 0; i < 64; i++) booked[i] = -1;
            div_end  = 0;
            deny_run = 0;
            m_sel    = '0;
            m_busy   = 1'b0;
        end else begin
            m_sel  = (booked[cyc % 64] >= 0) ? 4'(32'd1 << booked[cyc % 64]) : 4'd0;
            m_busy = (cyc < div_end);
            hold   = (deny_run >= SLIM);
            for (int u = 0; u < 4; u++) begin
                g[u] = rdy[u] && (booked[(cyc + lat_of(u)) % 64] < 0)
                       && (u == 0 || !hold) && (u != 2 || !m_busy);
            end
            if (rdy[0] && !g[0]) deny_run = (deny_run + 1 > SLIM) ? SLIM : deny_run + 1;
            else                 deny_run = 0;
            booked[cyc % 64] = -1;
            for (int u = 0; u < 4; u++) begin
                if (g[u]) booked[(cyc + lat_of(u)) % 64] = u;
            end
            if (g[2]) div_end = cyc + L_DIV;
        end
        m_done = g;
    endtask

    // One clock: drive just after the edge, sample well before the next one, compare to the model.
    task automatic cycle(input logic r, input logic [3:0] rdy);
        @(posedge clk);
        #1;
        cyc++;
        rst            = r;
        bus.int_ready  = rdy[0];
        bus.mult_ready = rdy[1];
        bus.div_ready  = rdy[2];
        bus.mem_ready  = rdy[3];
        #3;
        a_done  = {bus.mem_done, bus.div_done, bus.mult_done, bus.int_done};
        a_sel   = bus.cdb_sel;
        a_valid = bus.cdb_valid;
        a_busy  = bus.div_busy;
        model_step(r, rdy);
        chk("model_done",  a_done,  m_done);
        chk("model_sel",   a_sel,   m_sel);
        chk("model_valid", a_valid, |m_sel);
        chk("model_busy",  a_busy,  m_busy);
    endtask

    task automatic add(input logic r, input logic [3:0] rdy, input logic [3:0] done,
                       input logic [3:0] sel, input logic busy);
        vec_t v;
        v.r = r; v.rdy = rdy; v.done = done; v.sel = sel; v.busy = busy;
        tbl.push_back(v);
    endtask

    initial begin
        logic [3:0] rdy;
        logic       r;

        bus.int_ready = 0; bus.mult_ready = 0; bus.div_ready = 0; bus.mem_ready = 0;
        for (int i = 0; i < 64; i++) booked[i] = -1;

        // Reset with all ready high, release: all four granted, results return at 1,2,4,7.
        add(1, 4'hF, 4'h0, 4'h0, 0);
        add(1, 4'hF, 4'h0, 4'h0, 0);
        add(0, 4'hF, 4'hF, 4'h0, 0);
        add(0, 4'h0, 4'h0, 4'h1, 1);
        add(0, 4'h0, 4'h0, 4'h8, 1);
        add(0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 4'h2, 1);
        add(0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 4'h4, 0);
        add(0, 4'h0, 4'h0, 4'h0, 0);
        // Integer stream.
        add(0, 4'h1, 4'h1, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h1, 0);
        add(0, 4'h1, 4'h1, 4'h1, 0);
        add(0, 4'h1, 4'h1, 4'h1, 0);
        add(0, 4'h0, 4'h0, 4'h1, 0);
        add(0, 4'h0, 4'h0, 4'h0, 0);
        // Mult booking blocks int three cycles later.
        add(0, 4'h2, 4'h2, 4'h0, 0);
        add(0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h2, 0);
        add(0, 4'h0, 4'h0, 4'h1, 0);
        add(0, 4'h0, 4'h0, 4'h0, 0);
        // Reset mid-operation drops outstanding bookings.
        add(0, 4'h2, 4'h2, 4'h0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 5; i++) add(0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h0, 4'h0, 4'h0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].rdy);
            chk("tbl_done",  a_done,  tbl[i].done);
            chk("tbl_sel",   a_sel,   tbl[i].sel);
            chk("tbl_valid", a_valid, |tbl[i].sel);
            chk("tbl_busy",  a_busy,  tbl[i].busy);
        end

        // Divider held ready: non-pipelined, regranted when its result is on the CDB.
        for (int k = 0; k <= 14; k++) begin
            cycle(0, (k < 14) ? 4'b0100 : 4'b0000);
            chk("div_done", a_done, (k == 0 || k == 7) ? 4'b0100 : 4'b0000);
            chk("div_busy", a_busy, ((k >= 1 && k <= 6) || (k >= 8 && k <= 13)) ? 1'b1 : 1'b0);
            chk("div_sel",  a_sel,  (k == 7 || k == 14) ? 4'b0100 : 4'b0000);
        end

        // Mult stream starves int for SLIM cycles, hold drains the bus, int issues, mult resumes.
        for (int k = 0; k <= 15; k++) begin
            cycle(0, {2'b00, 1'b1, (k >= 3) ? 1'b1 : 1'b0});
            chk("starve_int",  a_done[0], (k >= 14) ? 1'b1 : 1'b0);
            chk("starve_mult", a_done[1], (k <= 10 || k >= 15) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 10; k++) cycle(0, 4'b0000);

        // Random traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 149) == 0);
            for (int b = 0; b < 4; b++) rdy[b] = ($urandom_range(0, 9) < ((b == 1) ? 8 : 5));
            cycle(r, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
